// File: rtl/fetch_seq.sv
// fetch_seq: owns the architectural PC and issues one instruction-memory request at a time.
// Optional jr target alignment check is compiled in with `define PC_ALIGN_CHK_EN.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [1:0]  redir_op,
    input  logic [31:0] redir_pc4,
    input  logic [25:0] redir_imm26,
    input  logic [31:0] redir_rs,
    input  logic        br_taken,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        misalign
);

    localparam logic [1:0] ST_ISSUE = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [1:0] OP_BR = 2'b00;
    localparam logic [1:0] OP_J  = 2'b01;
    localparam logic [1:0] OP_JR = 2'b10;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
    } redir_t;

    logic [1:0]  state;
    logic [31:0] pc;
    redir_t      pend;

    logic        redir_take;
    logic        jr_mis;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] redir_tgt;

    // Not-taken branches and the reserved op never disturb the fetch stream.
    always_comb begin
        br_tgt     = redir_pc4 + {{14{redir_imm26[15]}}, redir_imm26[15:0], 2'b00};
        j_tgt      = {redir_pc4[31:28], redir_imm26, 2'b00};
        redir_take = redir_valid &&
                     ((redir_op == OP_BR && br_taken) || redir_op == OP_J || redir_op == OP_JR);
`ifdef PC_ALIGN_CHK_EN
        jr_mis     = redir_take && redir_op == OP_JR && redir_rs[1:0] != 2'b00;
`else
        jr_mis     = 1'b0;
`endif
        case (redir_op)
            OP_BR:   redir_tgt = br_tgt;
            OP_J:    redir_tgt = j_tgt;
            default: redir_tgt = redir_rs;
        endcase
        if (jr_mis)
            redir_tgt = EXC_PC;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_ISSUE;
            pc        <= RESET_PC;
            pend      <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            if_valid  <= 1'b0;
            if_pc     <= '0;
            if_instr  <= '0;
        end else begin
            imem_req <= 1'b0;
            case (state)
                ST_ISSUE: begin
                    if_valid <= 1'b0;
                    if (redir_take) begin
                        pc <= redir_tgt;
                    end else if (!stall) begin
                        // Low bits masked so an unaligned jr target still fetches a word.
                        imem_req  <= 1'b1;
                        imem_addr <= {pc[31:2], 2'b00};
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if_valid <= 1'b0;
                    if (imem_ack) begin
                        pend.vld <= 1'b0;
                        if (redir_take) begin
                            pc    <= redir_tgt;
                            state <= ST_ISSUE;
                        end else if (pend.vld) begin
                            pc    <= pend.pc;
                            state <= ST_ISSUE;
                        end else begin
                            if_valid <= 1'b1;
                            if_pc    <= pc;
                            if_instr <= imem_rdata;
                            if (stall) begin
                                state <= ST_HOLD;
                            end else begin
                                pc    <= pc + 32'd4;
                                state <= ST_ISSUE;
                            end
                        end
                    end else if (redir_take) begin
                        // Latest redirect wins until the in-flight response returns.
                        pend.vld <= 1'b1;
                        pend.pc  <= redir_tgt;
                    end
                end
                ST_HOLD: begin
                    if (redir_take) begin
                        if_valid <= 1'b0;
                        pc       <= redir_tgt;
                        state    <= ST_ISSUE;
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                        pc       <= pc + 32'd4;
                        state    <= ST_ISSUE;
                    end
                end
                default: state <= ST_ISSUE;
            endcase
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic mis_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mis_q <= 1'b0;
        else
            mis_q <= jr_mis;
    end

    assign misalign = mis_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a latency-programmable memory responder plus a linear
// sequence of fetch, redirect, stall and reset scenarios with hand-computed addresses.
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redir_valid;
    logic [1:0]  redir_op;
    logic [31:0] redir_pc4;
    logic [25:0] redir_imm26;
    logic [31:0] redir_rs;
    logic        br_taken;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign;

    int tests = 0;
    int fails = 0;
    int lat   = 1;

    fetch_seq dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_op    (redir_op),
        .redir_pc4   (redir_pc4),
        .redir_imm26 (redir_imm26),
        .redir_rs    (redir_rs),
        .br_taken    (br_taken),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mword(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns on the cycle imem_req is high (current cycle included).
    task automatic wait_req(input string tag, input logic [31:0] exp);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (imem_req) got = 1'b1;
            else tick();
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
        chk(tag, imem_addr, exp);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (if_valid) got = 1'b1;
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
        chk({tag, "_pc"}, if_pc, exp_pc);
        chk({tag, "_instr"}, if_instr, mword(exp_pc));
    endtask

    task automatic wait_ack(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (imem_ack) got = 1'b1;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    task automatic redir(input logic [1:0] op, input logic [31:0] pc4, input logic [25:0] imm,
                         input logic [31:0] rs, input logic taken);
        redir_valid = 1'b1;
        redir_op    = op;
        redir_pc4   = pc4;
        redir_imm26 = imm;
        redir_rs    = rs;
        br_taken    = taken;
        tick();
        redir_valid = 1'b0;
        br_taken    = 1'b0;
    endtask

    // Memory responder: acks `lat` cycles after seeing a request; a reset aborts it.
    initial begin
        int          cnt;
        logic [31:0] a;
        cnt        = 0;
        a          = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            imem_ack = 1'b0;
            if (reset) begin
                cnt = 0;
            end else if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mword(a);
                end
            end else if (imem_req) begin
                a   = imem_addr;
                cnt = lat;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_jr;
        logic        exp_mis;
        reset       = 1'b1;
        stall       = 1'b0;
        redir_valid = 1'b0;
        redir_op    = 2'b00;
        redir_pc4   = '0;
        redir_imm26 = '0;
        redir_rs    = '0;
        br_taken    = 1'b0;
        repeat (2) tick();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_misalign", misalign, 0);
        reset = 1'b0;

        // Sequential fetch with 1-cycle memory.
        wait_req("seq_req0", 32'h3000);
        wait_valid("seq_v0", 32'h3000);
        tick();
        chk("seq_pulse0", if_valid, 0);
        wait_req("seq_req1", 32'h3004);
        wait_valid("seq_v1", 32'h3004);
        tick();
        chk("seq_pulse1", if_valid, 0);
        wait_req("seq_req2", 32'h3008);
        wait_valid("seq_v2", 32'h3008);
        tick();
        chk("seq_pulse2", if_valid, 0);

        // Taken branch while waiting: 0x3008 + (-8) = 0x3000; 0x300C response dropped.
        wait_req("br_req", 32'h300C);
        redir(2'b00, 32'h3008, 26'h000FFFE, 32'h0, 1'b1);
        tick();
        chk("br_drop", if_valid, 0);
        wait_req("br_tgt", 32'h3000);
        wait_valid("br_v", 32'h3000);

        // Jump in ISSUE: {0x3010[31:28], 0xC40, 00} = 0x3100.
        redir(2'b01, 32'h3010, 26'h0000C40, 32'h0, 1'b0);
        chk("j_noreq", imem_req, 0);
        chk("j_novalid", if_valid, 0);
        wait_req("j_tgt", 32'h3100);

        // Not-taken branch and reserved op leave the stream sequential.
        redir(2'b00, 32'h3008, 26'h000FFFE, 32'h0, 1'b0);
        wait_valid("nt_v", 32'h3100);
        wait_req("nt_req", 32'h3104);
        redir(2'b11, 32'h3010, 26'h0000C40, 32'h0, 1'b1);
        lat = 3;
        wait_valid("rsv_v", 32'h3104);

        // 3-cycle latency, stall over the ack for 4 cycles.
        wait_req("st_req", 32'h3108);
        wait_ack("st_ack");
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("st_valid", if_valid, 1);
            chk("st_pc", if_pc, 32'h3108);
            chk("st_instr", if_instr, mword(32'h3108));
            chk("st_noreq", imem_req, 0);
        end
        stall = 1'b0;
        tick();
        chk("st_release", if_valid, 0);
        wait_req("st_next", 32'h310C);

        // Redirect coincident with ack: {0, 0x800, 00} = 0x2000.
        wait_ack("co_ack");
        redir(2'b01, 32'h3010, 26'h0000800, 32'h0, 1'b0);
        chk("co_drop", if_valid, 0);
        wait_req("co_tgt", 32'h2000);
        wait_valid("co_v", 32'h2000);
        tick();
        wait_req("mid_req", 32'h2004);
        tick();
        chk("mid_if_pc_pre", if_pc, 32'h2000);
        reset = 1'b1;
        #1;
        chk("mid_rst_pc", if_pc, 0);
        chk("mid_rst_instr", if_instr, 0);
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_valid", if_valid, 0);
        lat = 1;
        repeat (2) tick();
        reset = 1'b0;
        wait_req("rst_first", 32'h3000);

        // jr to 0x3002 while the 0x3000 fetch is in flight.
`ifdef PC_ALIGN_CHK_EN
        exp_jr  = 32'h4180;
        exp_mis = 1'b1;
`else
        exp_jr  = 32'h3000;
        exp_mis = 1'b0;
`endif
        redir(2'b10, 32'h0, 26'h0, 32'h3002, 1'b0);
        chk("jr_mis", misalign, exp_mis);
        tick();
        chk("jr_mis_end", misalign, 0);
        chk("jr_drop", if_valid, 0);
        wait_req("jr_tgt", exp_jr);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Fetch sequencer that owns the architectural PC and drives instruction-memory requests, one outstanding at a time.
- Computes the next PC internally: sequential PC+4, branch (sign-extended offset from PC+4), j/jal (26-bit index), or jr (register value).
- Applies decode-stage redirects and hazard-unit stalls.
- Sits between the hazard/decode logic and instruction memory; feeds the IF/ID register.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_PC, 32'h0000_4180, exception vector (used only with the optional feature).

Ports:
- clk input 1 system clock, rising edge.
- reset input 1 asynchronous, active-high reset.
- stall input 1 hold the IF/ID output; no new request is issued.
- redir_valid input 1 one-cycle redirect from decode.
- redir_op input 2 00 branch, 01 j/jal, 10 jr, 11 reserved (ignored).
- redir_pc4 input 32 PC+4 of the redirecting instruction.
- redir_imm26 input 26 instruction bits [25:0].
- redir_rs input 32 register value for jr.
- br_taken input 1 branch condition; qualifies op 00 only.
- imem_req output 1 request strobe.
- imem_addr output 32 request address.
- imem_ack input 1 response valid; latency 1..N cycles after the request.
- imem_rdata input 32 instruction word, valid with imem_ack.
- if_valid output 1 instruction delivered this cycle.
- if_pc output 32 PC of the delivered instruction.
- if_instr output 32 delivered instruction.
- misalign output 1 jr target misaligned (feature only; tied 0 otherwise).

Behaviour:
- Reset (asynchronous):
  - pc = RESET_PC; state = ISSUE.
  - imem_req = 0, if_valid = 0, if_pc = 0, if_instr = 0, misalign = 0.
  - Pending-redirect buffer cleared.
- Target computation:
  - Branch: redir_pc4 + {{14{imm[15]}}, imm[15:0], 2'b00}, 32-bit wraparound.
  - Jump: {redir_pc4[31:28], imm26, 2'b00}.
  - jr: redir_rs.
  - Op 00 with br_taken = 0, or op 11: no redirect.
- States:
  - ISSUE: if !stall, imem_req = 1 with imem_addr = pc, then go to WAIT. If stall, imem_req = 0 and stay in ISSUE.
  - WAIT: imem_req = 0 while waiting for imem_ack.
    - On ack with no redirect pending and no redirect this cycle: if_valid = 1 for exactly 1 cycle, if_pc = pc, if_instr = imem_rdata; pc += 4; go to ISSUE.
    - On ack with a redirect pending or arriving this cycle: drop the response (if_valid = 0); pc = target; go to ISSUE.
  - HOLD: entered from WAIT when an ack arrives while stall = 1.
    - Latch the instruction. if_valid stays 1 while stall = 1, with if_pc and if_instr unchanged.
    - Leave to ISSUE in the first cycle stall = 0, with pc += 4.
    - A redirect in HOLD clears if_valid next cycle and loads pc = target.
- Redirect in ISSUE or HOLD: pc = target next cycle; no in-flight request exists.
- Redirect in WAIT without ack: store target in the pending buffer.
  - A second redirect before ack overwrites the buffer (last wins).
- Redirect and ack in the same cycle: the redirect wins; the response is dropped.
- Redirect and stall in the same cycle: the redirect is still accepted.
- imem_addr is registered; it equals pc while imem_req = 1 and holds its value otherwise.
- No delay slot: every fetch after the redirecting instruction that is still in flight is squashed.

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- Enabled:
  - A jr redirect whose redir_rs[1:0] != 0 redirects to EXC_PC instead.
  - misalign pulses 1 for one cycle in the cycle after the redirect.
  - Branch and jump targets are always aligned and never trigger it.
- Disabled:
  - misalign is constant 0.
  - A jr target is used as given; bits [1:0] are forced to 0 on imem_addr.

Test Plan:
- Reset, 1-cycle ack memory, no redirects: first request addr 0x3000. if_pc sequence 0x3000, 0x3004, 0x3008, each with if_valid for one cycle.
- Branch op 00, pc4 = 0x3008, imm = 0xFFFE, br_taken = 1, arriving while WAIT: in-flight response dropped; next imem_addr = 0x3000.
- j op 01, pc4 = 0x3010, imm26 = 0x0000C40 in ISSUE: next imem_addr = 0x3100. Same branch with br_taken = 0: sequential fetch continues.
- 3-cycle ack latency, stall asserted when the ack arrives for 4 cycles: if_valid and if_instr held for all 4 cycles. No imem_req until stall drops. Next addr is the previous addr + 4.
- Redirect coincident with imem_ack: response not delivered; pc = target. Reset asserted mid-WAIT: outputs clear immediately; first request after release is 0x3000.
- With PC_ALIGN_CHK_EN, jr rs = 0x3002: misalign = 1 for one cycle; next imem_addr = 0x4180. Without the macro: imem_addr = 0x3000.
